// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle of the MEM-stage data memory.
// The CPU side drives requests through the master modport.
// The memory controller answers through the slave modport.
interface data_mem_ctrl_if;
  logic        i_req;
  logic        o_ready;
  logic        i_we;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_fault;
  logic        o_init_done;

  modport master (
    output i_req, i_we, i_size, i_unsigned, i_addr, i_wdata,
    input  o_ready, o_rdata, o_rvalid, o_fault, o_init_done
  );

  modport slave (
    input  i_req, i_we, i_size, i_unsigned, i_addr, i_wdata,
    output o_ready, o_rdata, o_rvalid, o_fault, o_init_done
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory for the CPU MEM stage.
// Supports byte, halfword and word accesses, and checks each request for
// alignment and address-range faults.
// Load results and fault tokens share one READ_LAT-deep pipeline, so they
// leave in request order.
// An optional sweep after reset zeroes every word before requests are
// accepted.
module data_mem_ctrl #(
  parameter int DEPTH          = 256,
  parameter int READ_LAT       = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  data_mem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [AW-1:0]       clr_idx_r;
  logic [AW-1:0]       clr_idx_next_s;
  logic                ready_r;
  logic                ready_next_s;

  logic [31:0]         mem_r [DEPTH];

  logic                accept_s;
  logic                align_flt_s;
  logic                range_flt_s;
  logic                fault_s;
  logic                ld_ok_s;
  logic                st_ok_s;
  logic [AW-1:0]       idx_s;
  logic [3:0]          be_s;
  logic [31:0]         wd_s;
  logic [31:0]         rd_word_s;
  logic [31:0]         load_val_s;

  logic [READ_LAT-1:0] lv_r;
  logic [READ_LAT-1:0] fv_r;
  logic [31:0]         data_r [READ_LAT];

  // Select the addressed lane and sign- or zero-extend it to 32 bits.
  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept_s    = bus.i_req && ready_r;
  assign range_flt_s = |bus.i_addr[31:AW+2];
  assign fault_s     = align_flt_s || range_flt_s;
  assign ld_ok_s     = accept_s && !fault_s && !bus.i_we;
  assign st_ok_s     = accept_s && !fault_s && bus.i_we;
  assign idx_s       = bus.i_addr[AW+1:2];
  assign rd_word_s   = mem_r[idx_s];
  assign load_val_s  = ext_load(rd_word_s, bus.i_size, bus.i_addr[1:0], bus.i_unsigned);

  // Alignment check, plus the byte-lane enables and replicated data for stores.
  always_comb begin
    align_flt_s = 1'b0;
    be_s        = 4'b0000;
    wd_s        = bus.i_wdata;
    case (bus.i_size)
      2'b00: begin
        be_s = 4'b0001 << bus.i_addr[1:0];
        wd_s = {4{bus.i_wdata[7:0]}};
      end
      2'b01: begin
        align_flt_s = bus.i_addr[0];
        be_s        = bus.i_addr[1] ? 4'b1100 : 4'b0011;
        wd_s        = {2{bus.i_wdata[15:0]}};
      end
      2'b10: begin
        align_flt_s = |bus.i_addr[1:0];
        be_s        = 4'b1111;
      end
      default: begin
        align_flt_s = 1'b1;
        be_s        = 4'b0000;
      end
    endcase
  end

  // Controller state: clear sweep, then serve requests.
  always_comb begin
    state_next_s   = state_r;
    clr_idx_next_s = clr_idx_r;
    case (state_r)
      ST_INIT: begin
        clr_idx_next_s = clr_idx_r + AW'(1);
        if (clr_idx_r == AW'(DEPTH - 1)) begin
          state_next_s = ST_READY;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_READY: state_next_s = ST_READY;
      default:  state_next_s = ST_READY;
    endcase
    ready_next_s = (state_next_s == ST_READY);
  end

  // State, sweep counter and the registered ready/init-done flag.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
      clr_idx_r <= {AW{1'b0}};
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      clr_idx_r <= clr_idx_next_s;
      ready_r   <= ready_next_s;
    end
  end

  // Memory array: the sweep writes zeros, and accepted stores update only the enabled lanes.
  always_ff @(posedge i_clock) begin
    if (state_r == ST_INIT) begin
      mem_r[clr_idx_r] <= 32'h00000000;
    end else if (st_ok_s) begin
      for (int k = 0; k < 4; k++) begin
        if (be_s[k]) begin
          mem_r[idx_s][8*k +: 8] <= wd_s[8*k +: 8];
        end
      end
    end
  end

  // Result pipeline.
  // The data stage only advances on real load data, so the final stage holds
  // the last valid value.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lv_r <= {READ_LAT{1'b0}};
      fv_r <= {READ_LAT{1'b0}};
      for (int i = 0; i < READ_LAT; i++) begin
        data_r[i] <= 32'h00000000;
      end
    end else begin
      lv_r[0] <= ld_ok_s;
      fv_r[0] <= accept_s && fault_s;
      if (ld_ok_s) begin
        data_r[0] <= load_val_s;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        lv_r[i] <= lv_r[i-1];
        fv_r[i] <= fv_r[i-1];
        if (lv_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign bus.o_ready     = ready_r;
  assign bus.o_init_done = ready_r;
  assign bus.o_rvalid    = lv_r[READ_LAT-1];
  assign bus.o_fault     = fv_r[READ_LAT-1];
  assign bus.o_rdata     = data_r[READ_LAT-1];
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl. Three instances share one clock, one reset and one
// stimulus stream:
//   lat1: READ_LAT=1, with clear sweep
//   lat3: READ_LAT=3, with clear sweep
//   lat2: READ_LAT=2, without sweep (only handshake and strobes are checked)
// The reference model schedules each expected result slot in an edge-indexed table.
module tb_data_mem_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int ND    = 3;
  localparam int MAXE  = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        uns = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  always #5 clk = ~clk;

  data_mem_ctrl_if bus_a ();
  data_mem_ctrl_if bus_b ();
  data_mem_ctrl_if bus_c ();

  assign bus_a.i_req = req;   assign bus_b.i_req = req;   assign bus_c.i_req = req;
  assign bus_a.i_we = we;     assign bus_b.i_we = we;     assign bus_c.i_we = we;
  assign bus_a.i_size = size; assign bus_b.i_size = size; assign bus_c.i_size = size;
  assign bus_a.i_unsigned = uns;  assign bus_b.i_unsigned = uns;  assign bus_c.i_unsigned = uns;
  assign bus_a.i_addr = addr;     assign bus_b.i_addr = addr;     assign bus_c.i_addr = addr;
  assign bus_a.i_wdata = wdata;   assign bus_b.i_wdata = wdata;   assign bus_c.i_wdata = wdata;

  logic        rv [ND];
  logic        ft [ND];
  logic        rdy [ND];
  logic        idn [ND];
  logic [31:0] rdat [ND];

  assign rv[0] = bus_a.o_rvalid; assign ft[0] = bus_a.o_fault; assign rdy[0] = bus_a.o_ready;
  assign idn[0] = bus_a.o_init_done; assign rdat[0] = bus_a.o_rdata;
  assign rv[1] = bus_b.o_rvalid; assign ft[1] = bus_b.o_fault; assign rdy[1] = bus_b.o_ready;
  assign idn[1] = bus_b.o_init_done; assign rdat[1] = bus_b.o_rdata;
  assign rv[2] = bus_c.o_rvalid; assign ft[2] = bus_c.o_fault; assign rdy[2] = bus_c.o_ready;
  assign idn[2] = bus_c.o_init_done; assign rdat[2] = bus_c.o_rdata;

  data_mem_ctrl #(.DEPTH(DEPTH), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u_lat1 (
    .i_clock(clk), .i_reset_n(rst_n), .bus(bus_a));
  data_mem_ctrl #(.DEPTH(DEPTH), .READ_LAT(3), .CLEAR_ON_RESET(1'b1)) u_lat3 (
    .i_clock(clk), .i_reset_n(rst_n), .bus(bus_b));
  data_mem_ctrl #(.DEPTH(DEPTH), .READ_LAT(2), .CLEAR_ON_RESET(1'b0)) u_lat2 (
    .i_clock(clk), .i_reset_n(rst_n), .bus(bus_c));

  // Reference model state
  int          lat [ND]      = '{1, 3, 2};
  int          rdy_edge [ND] = '{DEPTH, DEPTH, 1};
  bit          chk_data [ND] = '{1'b1, 1'b1, 1'b0};
  int          kind_a [ND][MAXE];           // 0 idle slot, 1 load data, 2 fault
  logic [31:0] data_a [ND][MAXE];
  logic [31:0] last_m [ND];
  logic [31:0] mem_m [DEPTH];
  int          edge_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic bit ref_fault(input logic [1:0] sz, input logic [31:0] a);
    if (a >= 32'(4 * DEPTH)) return 1'b1;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [31:0] a, input logic u);
    logic [31:0] v;
    int sh;
    case (sz)
      2'd0: begin
        sh = 8 * int'(a[1:0]);
        v = (w >> sh) & 32'h000000FF;
        if (!u && v >= 32'h00000080) v = v + 32'hFFFFFF00;
      end
      2'd1: begin
        sh = 16 * int'(a[1]);
        v = (w >> sh) & 32'h0000FFFF;
        if (!u && v >= 32'h00008000) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int idx;
    int sh;
    logic [31:0] mask;
    idx = int'(a[AW+1:2]);
    mask = 32'hFFFFFFFF;
    sh = 0;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'h000000FF << sh;
    end else if (sz == 2'd1) begin
      sh = 16 * int'(a[1]);
      mask = 32'h0000FFFF << sh;
    end
    mem_m[idx] = (mem_m[idx] & ~mask) | ((wd << sh) & mask);
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d] edge %0d: observed %h, expected %h", tag, d, edge_cnt, obs, exp);
    end
  endtask

  // One clock: model the upcoming edge, take the edge, then check every instance.
  task automatic cycle();
    int e;
    int src;
    int k;
    e = edge_cnt + 1;
    if (e >= MAXE) begin
      $display("FAIL edge_budget: edge %0d exceeds table size %0d", e, MAXE);
      $fatal(1, "edge table overflow");
    end
    for (int d = 0; d < ND; d++) begin
      kind_a[d][e] = 0;
      if (rst_n && req && e > rdy_edge[d]) begin
        if (ref_fault(size, addr)) begin
          kind_a[d][e] = 2;
        end else if (!we) begin
          kind_a[d][e] = 1;
          data_a[d][e] = ref_load(mem_m[int'(addr[AW+1:2])], size, addr, uns);
        end
      end
    end
    if (rst_n && req && we && e > DEPTH && !ref_fault(size, addr)) ref_store(size, addr, wdata);
    @(posedge clk);
    if (rst_n) edge_cnt = e;
    #1;
    for (int d = 0; d < ND; d++) begin
      src = edge_cnt - lat[d] + 1;
      k = (rst_n && src >= 1) ? kind_a[d][src] : 0;
      if (k == 1) last_m[d] = data_a[d][src];
      chk("rvalid", d, 32'(rv[d]), 32'(k == 1));
      chk("fault", d, 32'(ft[d]), 32'(k == 2));
      chk("ready", d, 32'(rdy[d]), 32'(rst_n && edge_cnt >= rdy_edge[d]));
      chk("init_done", d, 32'(idn[d]), 32'(rst_n && edge_cnt >= rdy_edge[d]));
      if (chk_data[d]) chk("rdata", d, rdat[d], last_m[d]);
    end
  endtask

  // Assert reset between edges, check that outputs clear at once, hold for two edges, then release.
  task automatic do_reset();
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      last_m[d] = 32'h0;
      chk("rst_ready", d, 32'(rdy[d]), 32'h0);
      chk("rst_init_done", d, 32'(idn[d]), 32'h0);
      chk("rst_rvalid", d, 32'(rv[d]), 32'h0);
      chk("rst_fault", d, 32'(ft[d]), 32'h0);
      chk("rst_rdata", d, rdat[d], 32'h0);
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    edge_cnt = 0;
    repeat (2) cycle();
    rst_n = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic op(input logic w, input logic [1:0] s, input logic u,
                    input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = wd;
    cycle();
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    #1;
    do_reset();
    // Sweep: requests issued while not ready must be ignored by the sweeping instances.
    idle(4);
    op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    op(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678);
    idle(DEPTH - 6);
    // After the sweep, every word reads back as zero; back-to-back loads return in order.
    for (int i = 0; i < DEPTH; i++) op(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0);
    idle(4);
    // A load issued right after a store to the same word sees the new data.
    op(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    idle(3);
    // Byte store, then signed and unsigned byte loads and a word load.
    op(1'b1, 2'b00, 1'b0, 32'h9, 32'h00000080);
    op(1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
    op(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    op(1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
    op(1'b0, 2'b01, 1'b1, 32'h8, 32'h0);
    idle(4);
    // Faults: misaligned halfword, misaligned word store, out of range, reserved size.
    op(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    op(1'b1, 2'b10, 1'b0, 32'h2, 32'hCAFEF00D);
    op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0);
    op(1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
    op(1'b1, 2'b00, 1'b0, 32'h80000001, 32'h55);
    op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    idle(4);
    // Four consecutive loads.
    op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
    idle(4);
    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      we    = $urandom_range(0, 1) == 1;
      size  = 2'($urandom_range(0, 3));
      uns   = $urandom_range(0, 1) == 1;
      addr  = 32'($urandom_range(0, 4 * DEPTH + 7));
      if ($urandom_range(0, 31) == 0) addr = addr | 32'h80000000;
      wdata = $urandom;
      cycle();
    end
    idle(4);
    // Reset one edge after a load is accepted: that load must never emerge.
    op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    idle(1);
    do_reset();
    // Reset partway through the sweep: the sweep must restart and take DEPTH edges.
    idle(5);
    do_reset();
    idle(DEPTH);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0);
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
